// File: rtl/parallel_to_serial_pkg.sv
// Shared constants and FSM state type for the parallel-to-serial converter.
package parallel_to_serial_pkg;
    localparam int P2S_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_e;
endpackage

// File: rtl/parallel_to_serial.sv
// Parallel word to serial bit stream converter with a one-entry hold register
// so a new word can be taken while the previous one is still shifting out.
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int WIDTH     = P2S_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] p_i,
    input  logic             p_valid,
    output logic             p_ready,
    output logic             serial_out,
    output logic             s_valid,
    output logic             s_first,
    output logic             s_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    p2s_state_e       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rdy_q;
    logic             accept;
    logic             cnt_last;
    logic [WIDTH-1:0] shift_adv;

    assign accept    = p_valid && rdy_q;
    assign cnt_last  = (cnt_q == CW'(WIDTH - 1));
    assign shift_adv = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        // Accept only while hold is empty, so it never collides with a hold drain below.
        if (accept) begin
            hold_d      = p_i;
            hold_full_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_last && hold_full_q) begin
                    shift_d     = hold_q;
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                end else if (cnt_last) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    shift_d = shift_adv;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // p_ready is a flop of !hold_full so it stays low through reset and
    // rises only on the first clock edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            rdy_q       <= !hold_full_d;
        end
    end

    assign p_ready    = rdy_q;
    assign s_valid    = (state_q == SHIFT);
    assign serial_out = s_valid && (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
    assign s_first    = s_valid && (cnt_q == '0);
    assign s_last     = s_valid && cnt_last;
    assign busy       = (state_q == SHIFT) || hold_full_q;
endmodule

// File: doc/parallel_to_serial.md
PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = transmit bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 p_i  input  WIDTH  parallel word to transmit.
REQ-006 p_valid  input  1  p_i holds a valid word.
REQ-007 p_ready  output  1  block can accept a word this cycle.
REQ-008 serial_out  output  1  current serial bit.
REQ-009 s_valid  output  1  serial_out carries a valid bit this cycle.
REQ-010 s_first  output  1  first bit of a word (qualified by s_valid).
REQ-011 s_last  output  1  last bit of a word (qualified by s_valid).
REQ-012 busy  output  1  shifter active or hold register full.

Function
REQ-013 Handshake SHALL be valid/ready: a word is accepted on a rising edge where p_valid=1 and p_ready=1; p_valid without p_ready SHALL NOT be lost or consumed.
REQ-014 Internal state SHALL be a one-entry hold register (hold, hold_full), a WIDTH-bit shift register, a bit counter (0..WIDTH-1) and a two-state FSM: IDLE, SHIFT.
REQ-015 p_ready SHALL equal !hold_full, driven from registers only (no combinational path from p_valid).
REQ-016 An accepted word SHALL be written to hold and set hold_full at the accepting edge.
REQ-017 IDLE -> SHIFT: at the first edge where hold_full=1, the shifter loads hold, counter clears to 0, and hold_full clears.
REQ-018 In SHIFT each cycle SHALL present one bit: s_valid=1, serial_out = shifter MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0); the shifter advances one position and the counter increments each edge.
REQ-019 s_first SHALL be 1 when counter=0; s_last SHALL be 1 when counter=WIDTH-1.
REQ-020 At the s_last edge: if hold_full=1 the shifter reloads from hold (counter 0, stay in SHIFT, hold_full clears), giving gap-free back-to-back words; otherwise FSM returns to IDLE.
REQ-021 Latency: word accepted at edge k SHALL have its first bit on serial_out (s_valid=1, s_first=1) in the cycle after edge k+1 when the FSM is IDLE at k.
REQ-022 Sustained throughput SHALL be one word per WIDTH cycles with no s_valid gaps while p_valid stays asserted.
REQ-023 In IDLE: s_valid=0, s_first=0, s_last=0, serial_out=0.
REQ-024 busy SHALL equal (state==SHIFT) || hold_full.
REQ-025 p_i SHALL be sampled only at the accepting edge; later changes to p_i SHALL NOT affect the word in flight.

Reset
REQ-026 While rst_n=0: FSM=IDLE, hold_full=0, shifter=0, counter=0; outputs serial_out=0, s_valid=0, s_first=0, s_last=0, busy=0, p_ready=0.
REQ-027 p_ready SHALL rise on the first clk edge after rst_n deasserts, not asynchronously.
REQ-028 Reset asserted mid-word SHALL abort the word and discard hold contents immediately; no partial word resumes after release.

Structure
REQ-029 A shared package SHALL hold the default WIDTH constant and the FSM state typedef (IDLE, SHIFT).
REQ-030 The design SHALL be a single module; no sub-module.

Verification
REQ-031 Single word, WIDTH=4, MSB_FIRST=1: p_i=4'b1011 accepted at edge k -> serial_out 1,0,1,1 in cycles k+2..k+5; s_first in cycle k+2, s_last in cycle k+5; then IDLE.
REQ-032 Back-to-back: words 4'hA, 4'h5, 4'hF with p_valid held -> 12 consecutive s_valid cycles, bits 1010 0101 1111, no gap; p_ready low whenever hold_full=1.
REQ-033 Backpressure: p_valid held with p_i=4'h3 while hold full -> word neither dropped nor duplicated; exactly one 0011 frame per accepted handshake.
REQ-034 MSB_FIRST=0, p_i=4'b1011 -> serial_out 1,1,0,1.
REQ-035 Reset mid-word: rst_n low during bit 2 of 4'hC with 4'h9 in hold -> outputs zero immediately; after release no bits of 4'hC or 4'h9 appear; next accepted 4'h6 sends 0110.
REQ-036 Loopback into a 4-bit serial-to-parallel receiver clocked on clk, sampling only when s_valid=1: random words -> receiver word equals sent word after each s_last.
